// File: rtl/req_queue_bank_if.sv
// Bus bundle between the per-channel request queues and their producer/arbiter side.
// Carries push handshake, per-channel req/head-word presentation, grants and status.
// slave = queue bank, master = producer plus arbiter (or a testbench standing in for both).
interface req_queue_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data_out;
  logic [3:0]         grant;
  logic [4*LW-1:0]    level;
  logic [3:0]         drop;

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, data_out, level, drop
  );

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, data_out, level, drop
  );
endinterface

// File: rtl/req_queue_bank.sv
// Four independent request FIFOs feeding the 4-channel arbiter; req = non-empty, head word shown on data_out.
// Latency: push visible on req/data_out the cycle after the push edge; pop on grant edge.
// Backpressure: in_ready drops when a FIFO is full (no same-cycle pass-through); pushes while full are dropped and flagged.
// Optional grant checker enabled by macro REQ_QUEUE_GRANT_CHECK_EN (adds sticky grant_err output).
module req_queue_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  req_queue_bank_if.slave bus
`ifdef REQ_QUEUE_GRANT_CHECK_EN
  ,
  output logic grant_err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Flattened per-channel status collected from the channel slices below.
  logic [3:0]         ready_vec;
  logic [3:0]         req_vec;
  logic [3:0]         drop_vec;
  logic [4*WIDTH-1:0] head_vec;
  logic [4*LW-1:0]    level_vec;

  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [LW-1:0]    cnt;
    logic             drop_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Occupancy is the single source of truth for full/empty; pointers just wrap.
    assign full  = (cnt == FULL_LVL);
    assign empty = (cnt == '0);
    assign push  = bus.in_valid[c] & ~full;
    assign pop   = bus.grant[c] & ~empty;

    assign ready_vec[c]                 = ~full;
    assign req_vec[c]                   = ~empty;
    assign drop_vec[c]                  = drop_q;
    assign head_vec[c*WIDTH +: WIDTH]   = empty ? '0 : mem[head];
    assign level_vec[c*LW +: LW]        = cnt;

    // Storage write at the tail; reset wins over a coincident push.
    always_ff @(posedge clk) begin
      if (!rst && push) begin
        mem[tail] <= bus.in_data[c*WIDTH +: WIDTH];
      end
    end

    // Pointer and occupancy update; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk) begin
      if (rst) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    // Sticky overflow flag: any offer while full is lost and remembered until reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        drop_q <= 1'b0;
      end else if (bus.in_valid[c] && full) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready = ready_vec;
  assign bus.req      = req_vec;
  assign bus.drop     = drop_vec;
  assign bus.data_out = head_vec;
  assign bus.level    = level_vec;

`ifdef REQ_QUEUE_GRANT_CHECK_EN
  logic grant_multi;
  logic grant_idle;
  logic grant_bad;

  // A legal grant is zero or one-hot and only targets a requesting channel.
  assign grant_multi = |(bus.grant & (bus.grant - 4'd1));
  assign grant_idle  = |(bus.grant & ~req_vec);
  assign grant_bad   = grant_multi | grant_idle;

  // Sticky protocol error flag for the arbiter contract.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_err <= 1'b0;
    end else if (grant_bad) begin
      grant_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of the same arbiter protocol violation.
  always_ff @(posedge clk) begin
    if (!rst && grant_bad) begin
      $error("req_queue_bank: illegal grant %b with req %b", bus.grant, req_vec);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_req_queue_bank.sv
// Directed self-checking bench for req_queue_bank (WIDTH=8, DEPTH=4).
// Inputs are driven 1 time unit after a rising edge and outputs are checked there too.
// Each scenario task performs its own comparisons against hand-computed values.
module tb_req_queue_bank;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  req_queue_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef REQ_QUEUE_GRANT_CHECK_EN
  logic grant_err;
`endif

  req_queue_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef REQ_QUEUE_GRANT_CHECK_EN
    ,
    .grant_err (grant_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] dat(input int c);
    return bus.data_out[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [LW-1:0] lvl(input int c);
    return bus.level[c*LW +: LW];
  endfunction

  task automatic do_reset();
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.grant    = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push1(input int c, input logic [WIDTH-1:0] d);
    bus.in_valid = 4'b0001 << c;
    bus.in_data  = '0;
    bus.in_data[c*WIDTH +: WIDTH] = d;
    tick();
    bus.in_valid = '0;
  endtask

  task automatic pop1(input int c);
    bus.grant = 4'b0001 << c;
    tick();
    bus.grant = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.req !== 4'b0000) begin bad++; $display("FAIL reset_req got=%b exp=0000", bus.req); end
    total++; if (bus.in_ready !== 4'b1111) begin bad++; $display("FAIL reset_ready got=%b exp=1111", bus.in_ready); end
    total++; if (bus.level !== 12'h000) begin bad++; $display("FAIL reset_level got=%h exp=000", bus.level); end
    total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=00000000", bus.data_out); end
    total++; if (bus.drop !== 4'b0000) begin bad++; $display("FAIL reset_drop got=%b exp=0000", bus.drop); end
    pop1(0);
    total++; if (bus.level !== 12'h000) begin bad++; $display("FAIL idle_grant_level got=%h exp=000", bus.level); end
    total++; if (bus.req !== 4'b0000) begin bad++; $display("FAIL idle_grant_req got=%b exp=0000", bus.req); end
    // A later push must land at slot 0 and show up immediately at the head.
    push1(0, 8'h5A);
    total++; if (dat(0) !== 8'h5A) begin bad++; $display("FAIL idle_grant_head got=%h exp=5a", dat(0)); end
  endtask

  task automatic test_single_word();
    do_reset();
    bus.in_valid = 4'b1111;
    bus.in_data  = 32'hD4C3B2A1;
    tick();
    bus.in_valid = '0;
    total++; if (bus.req !== 4'b1111) begin bad++; $display("FAIL single_req got=%b exp=1111", bus.req); end
    total++; if (bus.data_out !== 32'hD4C3B2A1) begin bad++; $display("FAIL single_data got=%h exp=d4c3b2a1", bus.data_out); end
    total++; if (bus.level !== 12'h249) begin bad++; $display("FAIL single_level got=%h exp=249", bus.level); end
    pop1(2);
    total++; if (bus.req !== 4'b1011) begin bad++; $display("FAIL single_pop_req got=%b exp=1011", bus.req); end
    total++; if (lvl(2) !== 3'd0) begin bad++; $display("FAIL single_pop_level got=%0d exp=0", lvl(2)); end
    total++; if (bus.data_out !== 32'hD400B2A1) begin bad++; $display("FAIL single_pop_data got=%h exp=d400b2a1", bus.data_out); end
  endtask

  task automatic test_order_wrap();
    logic [WIDTH-1:0] exp_q [4];
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
    do_reset();
    for (int i = 0; i < 4; i++) push1(1, 8'h10 + 8'(i));
    total++; if (bus.in_ready !== 4'b1101) begin bad++; $display("FAIL order_full_ready got=%b exp=1101", bus.in_ready); end
    total++; if (lvl(1) !== 3'd4) begin bad++; $display("FAIL order_full_level got=%0d exp=4", lvl(1)); end
    total++; if (dat(1) !== 8'h10) begin bad++; $display("FAIL order_head0 got=%h exp=10", dat(1)); end
    // Pop while full: ready must stay low during that cycle, reopen afterwards.
    bus.grant = 4'b0010;
    total++; if (bus.in_ready[1] !== 1'b0) begin bad++; $display("FAIL order_no_passthru got=%b exp=0", bus.in_ready[1]); end
    tick();
    bus.grant = '0;
    total++; if (dat(1) !== 8'h11) begin bad++; $display("FAIL order_head1 got=%h exp=11", dat(1)); end
    pop1(1);
    total++; if (dat(1) !== 8'h12) begin bad++; $display("FAIL order_head2 got=%h exp=12", dat(1)); end
    total++; if (lvl(1) !== 3'd2) begin bad++; $display("FAIL order_level2 got=%0d exp=2", lvl(1)); end
    push1(1, 8'h14);
    push1(1, 8'h15);
    total++; if (lvl(1) !== 3'd4) begin bad++; $display("FAIL wrap_level got=%0d exp=4", lvl(1)); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dat(1) !== exp_q[i]) begin bad++; $display("FAIL wrap_drain%0d got=%h exp=%h", i, dat(1), exp_q[i]); end
      pop1(1);
    end
    total++; if (bus.req[1] !== 1'b0) begin bad++; $display("FAIL wrap_empty_req got=%b exp=0", bus.req[1]); end
    total++; if (dat(1) !== 8'h00) begin bad++; $display("FAIL wrap_empty_data got=%h exp=00", dat(1)); end
  endtask

  task automatic test_push_pop();
    do_reset();
    push1(0, 8'h21);
    push1(0, 8'h22);
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h00000055;
    bus.grant    = 4'b0001;
    tick();
    bus.in_valid = '0;
    bus.grant    = '0;
    total++; if (lvl(0) !== 3'd2) begin bad++; $display("FAIL pp_level got=%0d exp=2", lvl(0)); end
    total++; if (dat(0) !== 8'h22) begin bad++; $display("FAIL pp_head got=%h exp=22", dat(0)); end
    pop1(0);
    total++; if (dat(0) !== 8'h55) begin bad++; $display("FAIL pp_tail got=%h exp=55", dat(0)); end
    pop1(0);
    total++; if (bus.req[0] !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", bus.req[0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) push1(3, 8'hE0 + 8'(i));
    push1(3, 8'hEE);
    total++; if (bus.drop !== 4'b1000) begin bad++; $display("FAIL ovf_drop got=%b exp=1000", bus.drop); end
    total++; if (lvl(3) !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", lvl(3)); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dat(3) !== 8'hE0 + 8'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, dat(3), 8'hE0 + 8'(i)); end
      pop1(3);
    end
    total++; if (dat(3) !== 8'h00) begin bad++; $display("FAIL ovf_after_data got=%h exp=00", dat(3)); end
    total++; if (bus.drop !== 4'b1000) begin bad++; $display("FAIL ovf_sticky got=%b exp=1000", bus.drop); end
    do_reset();
    total++; if (bus.drop !== 4'b0000) begin bad++; $display("FAIL ovf_clear got=%b exp=0000", bus.drop); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 4'b1111;
      bus.in_data  = {8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i), 8'h40 + 8'(i)};
      tick();
    end
    bus.in_valid = '0;
    total++; if (bus.level !== 12'h6DB) begin bad++; $display("FAIL mid_level3 got=%h exp=6db", bus.level); end
    rst          = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_data  = 32'hAABBCCDD;
    bus.grant    = 4'b0001;
    tick();
    rst          = 1'b0;
    bus.in_valid = '0;
    bus.grant    = '0;
    total++; if (bus.req !== 4'b0000) begin bad++; $display("FAIL mid_req got=%b exp=0000", bus.req); end
    total++; if (bus.level !== 12'h000) begin bad++; $display("FAIL mid_level got=%h exp=000", bus.level); end
    total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL mid_data got=%h exp=00000000", bus.data_out); end
    total++; if (bus.drop !== 4'b0000) begin bad++; $display("FAIL mid_drop got=%b exp=0000", bus.drop); end
    push1(2, 8'h77);
    total++; if (dat(2) !== 8'h77) begin bad++; $display("FAIL mid_fresh got=%h exp=77", dat(2)); end
    total++; if (lvl(2) !== 3'd1) begin bad++; $display("FAIL mid_fresh_level got=%0d exp=1", lvl(2)); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.grant    = '0;
    #1;
    test_reset();
    test_single_word();
    test_order_wrap();
    test_push_pop();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
